// File: rtl/led_blink_bank_if.sv
// Config port for led_blink_bank: valid/ready request plus a one-cycle error pulse.
// The master drives the request; the slave returns ready and the error pulse.
interface led_blink_bank_if #(
  parameter int HALF_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [3:0]        cfg_ch;
  logic [1:0]        cfg_mode;
  logic [HALF_W-1:0] cfg_half;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_half,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_half,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/led_blink_bank.sv
// Multi-channel LED blinker on a shared 1 ms tick; config lands on leds one cycle after accept.
// cfg_ready drops for one cycle after every accept. LED_BLINK_SYNC_EN adds a sync_req phase-align input.
module led_blink_bank #(
  parameter int TICK_DIV = 27_000,
  parameter int N_CH     = 4,
  parameter int HALF_W   = 16,
  parameter int DEF_HALF = 500
) (
  input  logic                fpga_CLK_AUX,
  input  logic                fpga_NRST,
`ifdef LED_BLINK_SYNC_EN
  input  logic                sync_req,
`endif
  led_blink_bank_if.slave     cfg,
  output logic [N_CH-1:0]     leds,
  output logic [N_CH-1:0]     oneshot_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    M_OFF     = 2'd0,
    M_ON      = 2'd1,
    M_BLINK   = 2'd2,
    M_ONESHOT = 2'd3
  } mode_e;

  logic [PW-1:0]     r_presc;
  logic              r_cfg_ready;
  logic              r_cfg_err;
  mode_e             r_mode [N_CH];
  logic [HALF_W-1:0] r_half [N_CH];
  logic [HALF_W-1:0] r_cnt  [N_CH];
  logic [N_CH-1:0]   r_led;
  logic [N_CH-1:0]   r_done;

  logic [PW-1:0]     w_presc_nxt;
  mode_e             w_mode_nxt [N_CH];
  logic [HALF_W-1:0] w_half_nxt [N_CH];
  logic [HALF_W-1:0] w_cnt_nxt  [N_CH];
  logic [N_CH-1:0]   w_led_nxt;
  logic [N_CH-1:0]   w_done_nxt;

  logic              w_tick;
  logic              w_acc;
  logic              w_in_range;
  logic              w_hit;
  logic              w_sync;
  logic [HALF_W-1:0] w_eff_in;

`ifdef LED_BLINK_SYNC_EN
  assign w_sync = sync_req;
`else
  assign w_sync = 1'b0;
`endif

  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_acc      = cfg.cfg_valid & r_cfg_ready;
  assign w_in_range = ({1'b0, cfg.cfg_ch} < 5'(N_CH));
  assign w_hit      = w_acc & w_in_range;
  // Half-period is stored already clamped so the counter compare never sees zero.
  assign w_eff_in   = (cfg.cfg_half == '0) ? HALF_W'(1) : cfg.cfg_half;

  assign w_presc_nxt = (w_tick || w_sync) ? '0 : r_presc + 1'b1;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_mode_nxt[i] = r_mode[i];
      w_half_nxt[i] = r_half[i];
      w_cnt_nxt[i]  = r_cnt[i];
      w_led_nxt[i]  = r_led[i];
      w_done_nxt[i] = 1'b0;

      // A config to this channel beats both sync and tick on the same edge.
      if (w_hit && (cfg.cfg_ch == 4'(i))) begin
        w_mode_nxt[i] = mode_e'(cfg.cfg_mode);
        w_half_nxt[i] = w_eff_in;
        w_cnt_nxt[i]  = '0;
        w_led_nxt[i]  = (cfg.cfg_mode != 2'd0);
      end else if (w_sync) begin
        w_cnt_nxt[i] = '0;
        if (r_mode[i] == M_BLINK) begin
          w_led_nxt[i] = 1'b1;
        end
      end else if (w_tick) begin
        unique case (r_mode[i])
          M_BLINK: begin
            if (r_cnt[i] == r_half[i] - HALF_W'(1)) begin
              w_led_nxt[i] = ~r_led[i];
              w_cnt_nxt[i] = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + HALF_W'(1);
            end
          end
          M_ONESHOT: begin
            if (r_cnt[i] == r_half[i] - HALF_W'(1)) begin
              w_led_nxt[i]  = 1'b0;
              w_mode_nxt[i] = M_OFF;
              w_cnt_nxt[i]  = '0;
              w_done_nxt[i] = 1'b1;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + HALF_W'(1);
            end
          end
          default: begin
            w_cnt_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge fpga_CLK_AUX or negedge fpga_NRST) begin
    if (!fpga_NRST) begin
      r_presc     <= '0;
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_led       <= '0;
      r_done      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_mode[i] <= M_BLINK;
        r_half[i] <= HALF_W'(DEF_HALF);
        r_cnt[i]  <= '0;
      end
    end else begin
      r_presc     <= w_presc_nxt;
      r_cfg_ready <= ~w_acc;
      r_cfg_err   <= w_acc & ~w_in_range;
      r_led       <= w_led_nxt;
      r_done      <= w_done_nxt;
      for (int i = 0; i < N_CH; i++) begin
        r_mode[i] <= w_mode_nxt[i];
        r_half[i] <= w_half_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
      end
    end
  end

  assign cfg.cfg_ready = r_cfg_ready;
  assign cfg.cfg_err   = r_cfg_err;
  assign leds          = r_led;
  assign oneshot_done  = r_done;

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank: directed config sequence, checked every cycle against a tick-counting model.
module tb_led_blink_bank;
  localparam int TICK_DIV = 4;
  localparam int N_CH     = 4;
  localparam int HALF_W   = 16;
  localparam int DEF_HALF = 3;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] leds;
  logic [N_CH-1:0] oneshot_done;

  led_blink_bank_if #(.HALF_W(HALF_W)) cfg_if ();

  led_blink_bank #(
    .TICK_DIV (TICK_DIV),
    .N_CH     (N_CH),
    .HALF_W   (HALF_W),
    .DEF_HALF (DEF_HALF)
  ) dut (
    .fpga_CLK_AUX (clk),
    .fpga_NRST    (rst_n),
    .cfg          (cfg_if),
    .leds         (leds),
    .oneshot_done (oneshot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel remembers its mode, effective half-period, the LED level at
  // (re)start and how many ticks it has seen since; the LED follows by division.
  int              m_k;
  int              m_mode [N_CH];
  int              m_eff  [N_CH];
  int              m_n    [N_CH];
  bit              m_base [N_CH];
  bit              m_ready;
  bit              m_err;
  logic [N_CH-1:0] m_done;
  bit              m_tick;
  bit              m_acc;

  function automatic bit model_led(input int c);
    case (m_mode[c])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return m_base[c] ^ bit'((m_n[c] / m_eff[c]) % 2);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k     = 0;
      m_ready = 1'b0;
      m_err   = 1'b0;
      m_done  = '0;
      for (int c = 0; c < N_CH; c++) begin
        m_mode[c] = 2;
        m_eff[c]  = DEF_HALF;
        m_n[c]    = 0;
        m_base[c] = 1'b0;
      end
    end else begin
      m_k++;
      m_tick  = (m_k % TICK_DIV) == 0;
      m_acc   = (cfg_if.cfg_valid === 1'b1) && m_ready;
      m_err   = m_acc && (int'(cfg_if.cfg_ch) >= N_CH);
      m_ready = !m_acc;
      m_done  = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (m_acc && int'(cfg_if.cfg_ch) == c) begin
          m_mode[c] = int'(cfg_if.cfg_mode);
          m_eff[c]  = (cfg_if.cfg_half == 0) ? 1 : int'(cfg_if.cfg_half);
          m_n[c]    = 0;
          m_base[c] = 1'b1;
        end else if (m_tick && m_mode[c] >= 2) begin
          m_n[c]++;
          if (m_mode[c] == 3 && m_n[c] == m_eff[c]) begin
            m_done[c] = 1'b1;
            m_mode[c] = 0;
          end
        end
      end
    end
  end

  bit              chk_en = 1'b0;
  logic [N_CH-1:0] exp_leds;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < N_CH; c++) exp_leds[c] = model_led(c);
      chk("leds", 32'(leds), 32'(exp_leds));
      chk("oneshot_done", 32'(oneshot_done), 32'(m_done));
      chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ready));
      chk("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    end
  end

  int done2_cnt = 0;
  always @(negedge clk) if (oneshot_done[2] === 1'b1) done2_cnt++;

  // Called at a negedge; leaves the request up until the edge that accepts it.
  task automatic send(input logic [3:0] ch, input logic [1:0] mode, input logic [HALF_W-1:0] half);
    bit ok;
    ok = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_mode  = mode;
    cfg_if.cfg_half  = half;
    for (int t = 0; t < 20; t++) begin
      if (cfg_if.cfg_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: cfg_ready never seen for ch %0d, expected within 20 cycles", ch);
    end
  endtask

  int  toggles;
  bit  prev0;

  initial begin
    rst_n            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_half  = '0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'h0);

    @(negedge clk);
    chk("ready_after_first_edge", 32'(cfg_if.cfg_ready), 32'h1);
    repeat (10) @(negedge clk);
    chk("leds_before_first_toggle", 32'(leds), 32'h0);
    @(negedge clk);
    chk("leds_first_toggle_edge12", 32'(leds), 32'hF);
    repeat (12) @(negedge clk);
    chk("leds_second_toggle_edge24", 32'(leds), 32'h0);

    send(4'd1, 2'd1, 16'd5);
    chk("ch1_on", 32'(leds[1]), 32'h1);
    chk("ready_low_after_accept", 32'(cfg_if.cfg_ready), 32'h0);
    @(negedge clk);
    chk("ready_back_high", 32'(cfg_if.cfg_ready), 32'h1);
    repeat (100) @(negedge clk);
    chk("ch1_still_on", 32'(leds[1]), 32'h1);

    done2_cnt = 0;
    send(4'd2, 2'd3, 16'd2);
    chk("ch2_oneshot_start", 32'(leds[2]), 32'h1);
    repeat (40) @(negedge clk);
    chk("ch2_oneshot_pulses", 32'(done2_cnt), 32'h1);
    chk("ch2_oneshot_off", 32'(leds[2]), 32'h0);

    send(4'd0, 2'd2, 16'd0);
    repeat (4) @(negedge clk);
    toggles = 0;
    prev0   = leds[0];
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (leds[0] != prev0) toggles++;
      prev0 = leds[0];
    end
    chk("ch0_half0_toggles_16cyc", 32'(toggles), 32'd4);

    send(4'd7, 2'd1, 16'd1);
    chk("err_pulse", 32'(cfg_if.cfg_err), 32'h1);
    @(negedge clk);
    chk("err_pulse_ends", 32'(cfg_if.cfg_err), 32'h0);
    repeat (10) @(negedge clk);

    for (int t = 0; t < 20; t++) begin
      if (cfg_if.cfg_ready === 1'b1 && ((m_k + 1) % TICK_DIV) == 0) break;
      @(negedge clk);
    end
    send(4'd3, 2'd2, 16'd3);
    chk("ch3_on_tick_accept", 32'(leds[3]), 32'h1);
    repeat (30) @(negedge clk);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_leds", 32'(leds), 32'h0);
    chk("async_rst_ready", 32'(cfg_if.cfg_ready), 32'h0);
    chk("async_rst_done", 32'(oneshot_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    chk("post_rst_before_toggle", 32'(leds), 32'h0);
    @(negedge clk);
    chk("post_rst_toggle_edge12", 32'(leds), 32'hF);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
